// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct constants,
// ALU operation encodings and the decoded-control bundle.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOP = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic       reads_rt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Anything not matched stays an illegal NOP with every other flag low.
  function automatic ctrl_t decode_ctrl(input logic [31:0] ir);
    ctrl_t c;
    c = '0;
    c.alu_op  = ALU_NOP;
    c.illegal = 1'b1;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          FN_ADD:  begin c.alu_op = ALU_ADD; c.illegal = 1'b0; end
          FN_SUB:  begin c.alu_op = ALU_SUB; c.illegal = 1'b0; end
          FN_AND:  begin c.alu_op = ALU_AND; c.illegal = 1'b0; end
          FN_OR:   begin c.alu_op = ALU_OR;  c.illegal = 1'b0; end
          FN_SLT:  begin c.alu_op = ALU_SLT; c.illegal = 1'b0; end
          default: c.illegal = 1'b1;
        endcase
        if (!c.illegal) begin
          c.rd        = ir[15:11];
          c.reads_rt  = 1'b1;
          c.reg_write = 1'b1;
        end
      end
      OP_ADDI: begin
        c.alu_op = ALU_ADD; c.illegal = 1'b0;
        c.rd = ir[20:16]; c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.alu_op = ALU_ADD; c.illegal = 1'b0;
        c.rd = ir[20:16]; c.reg_write = 1'b1; c.mem_read = 1'b1;
      end
      OP_SW: begin
        c.alu_op = ALU_ADD; c.illegal = 1'b0;
        c.reads_rt = 1'b1; c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.alu_op = ALU_SUB; c.illegal = 1'b0;
        c.reads_rt = 1'b1; c.branch = 1'b1;
      end
      OP_J: begin
        c.illegal = 1'b0; c.jump = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Two-read, one-write register file with $0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs_addr,
  input  logic [4:0]      rt_addr,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // A write landing this edge is visible to a read of the same index now.
  assign rs_data = (rs_addr == '0) ? '0 :
                   (we && waddr == rs_addr) ? wdata : regs[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 :
                   (we && waddr == rt_addr) ? wdata : regs[rt_addr];
`else
  assign rs_data = (rs_addr == '0) ? '0 : regs[rs_addr];
  assign rt_data = (rt_addr == '0) ? '0 : regs[rt_addr];
`endif

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: decode, register read, load-use stall and the
// valid/ready output register feeding EX. Build option: REGFILE_BYPASS_EN.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] pc_in,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] rt_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic [3:0]      alu_op,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  ctrl_t           ctrl;
  logic [XLEN-1:0] rf_rs;
  logic [XLEN-1:0] rf_rt;
  logic [XLEN-1:0] imm_next;
  logic            load_use_stall;
  logic            accept;

  regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .rs_addr(ir[25:21]),
    .rt_addr(ir[20:16]),
    .rs_data(rf_rs),
    .rt_data(rf_rt),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign ctrl = decode_ctrl(ir);

  // A load still in EX cannot supply its result to the instruction behind it.
  assign load_use_stall = ex_mem_read && (ex_rd != '0) &&
                          ((ex_rd == ir[25:21]) || ((ex_rd == ir[20:16]) && ctrl.reads_rt));
  assign if_ready = (!id_valid || ex_ready) && !load_use_stall;
  assign accept   = if_valid && if_ready;

  always_comb begin
    imm_next = {{(XLEN-16){ir[15]}}, ir[15:0]};
    if (ctrl.jump) imm_next = XLEN'({pc_in[XLEN-1 -: 4], ir[25:0], 2'b00});
  end

  // Flush wins over acceptance; a bubble only clears validity and the control flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid  <= 1'b0;
      rs_data   <= '0;
      rt_data   <= '0;
      imm       <= '0;
      pc_out    <= '0;
      rd        <= '0;
      alu_op    <= '0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      jump      <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush || (!accept && ex_ready)) begin
      id_valid  <= 1'b0;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      jump      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      id_valid  <= 1'b1;
      rs_data   <= rf_rs;
      rt_data   <= rf_rt;
      imm       <= imm_next;
      pc_out    <= pc_in;
      rd        <= ctrl.rd;
      alu_op    <= ctrl.alu_op;
      reg_write <= ctrl.reg_write;
      mem_read  <= ctrl.mem_read;
      mem_write <= ctrl.mem_write;
      branch    <= ctrl.branch;
      jump      <= ctrl.jump;
      illegal   <= ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: a mnemonic-level reference model compared
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] ir;
  logic [31:0] pc_in;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] rs_data, rt_data, imm, pc_out;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        reg_write, mem_read, mem_write, branch, jump, illegal;

  int total = 0;
  int bad   = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .ir(ir),
    .pc_in(pc_in), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .pc_out(pc_out), .rd(rd), .alu_op(alu_op), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs, rt, imm, pc;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw, mr, mw, br, jp, il;
  } exp_t;

  exp_t        m_state = '0;
  logic [31:0] m_regs [32];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic string mnemonic(input logic [31:0] instr);
    case (instr[31:26])
      6'h00: case (instr[5:0])
               6'h20: return "add";
               6'h22: return "sub";
               6'h24: return "and";
               6'h25: return "or";
               6'h2A: return "slt";
               default: return "ill";
             endcase
      6'h08: return "addi";
      6'h23: return "lw";
      6'h2B: return "sw";
      6'h04: return "beq";
      6'h02: return "j";
      default: return "ill";
    endcase
  endfunction

  function automatic logic is_rtype(input string m);
    return m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt";
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wb_we && wb_addr == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic logic model_ready();
    string m     = mnemonic(ir);
    logic  rt_rd = is_rtype(m) || m == "sw" || m == "beq";
    logic  stall = ex_mem_read && ex_rd != 0 &&
                   (ex_rd == ir[25:21] || (ex_rd == ir[20:16] && rt_rd));
    return (!m_state.valid || ex_ready) && !stall;
  endfunction

  function automatic exp_t model_next();
    exp_t  e = m_state;
    string m = mnemonic(ir);
    if (!flush && if_valid && model_ready()) begin
      e = '0;
      e.valid = 1'b1;
      e.rs  = model_read(ir[25:21]);
      e.rt  = model_read(ir[20:16]);
      e.pc  = pc_in;
      e.imm = (m == "j") ? {pc_in[31:28], ir[25:0], 2'b00} : {{16{ir[15]}}, ir[15:0]};
      e.rd  = is_rtype(m) ? ir[15:11] : (m == "addi" || m == "lw") ? ir[20:16] : 5'd0;
      case (m)
        "add", "addi", "lw", "sw": e.alu = 4'd0;
        "sub", "beq":              e.alu = 4'd1;
        "and":                     e.alu = 4'd2;
        "or":                      e.alu = 4'd3;
        "slt":                     e.alu = 4'd4;
        default:                   e.alu = 4'd15;
      endcase
      e.rw = is_rtype(m) || m == "addi" || m == "lw";
      e.mr = (m == "lw");
      e.mw = (m == "sw");
      e.br = (m == "beq");
      e.jp = (m == "j");
      e.il = (m == "ill");
    end else if (flush || ex_ready) begin
      e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.il = 0;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= '0;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
    end else begin
      m_state <= model_next();
      if (wb_we && wb_addr != 0) m_regs[wb_addr] <= wb_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("m_if_ready", if_ready, model_ready());
      checkOutput("m_id_valid", id_valid, m_state.valid);
      checkOutput("m_flags", {reg_write, mem_read, mem_write, branch, jump, illegal},
                  {m_state.rw, m_state.mr, m_state.mw, m_state.br, m_state.jp, m_state.il});
      if (m_state.valid) begin
        checkOutput("m_rs_data", rs_data, m_state.rs);
        checkOutput("m_rt_data", rt_data, m_state.rt);
        checkOutput("m_imm", imm, m_state.imm);
        checkOutput("m_pc_out", pc_out, m_state.pc);
        checkOutput("m_rd", rd, m_state.rd);
        checkOutput("m_alu_op", alu_op, m_state.alu);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic exr, input logic fl);
    if_valid = v; ir = instr; pc_in = pc; ex_ready = exr; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wb_we = 0; ex_mem_read = 0; flush = 0;
  endtask

  initial begin
    rst = 1; wb_we = 0; wb_addr = 0; wb_data = 0; ex_mem_read = 0; ex_rd = 0;
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_id_valid", id_valid, 0);
    checkOutput("rst_if_ready", if_ready, 1);
    rst = 0;

    wb_we = 1; wb_addr = 1; wb_data = 5; step();
    wb_we = 1; wb_addr = 2; wb_data = 7; step();

    applyStimulus(1, 32'h00221820, 32'h104, 1, 0); step();
    checkOutput("add_valid", id_valid, 1);
    checkOutput("add_rs", rs_data, 5);
    checkOutput("add_rt", rt_data, 7);
    checkOutput("add_rd", rd, 3);
    checkOutput("add_alu", alu_op, 0);
    checkOutput("add_rw", reg_write, 1);

    applyStimulus(1, 32'h8C24FFFC, 32'h108, 1, 0); step();
    checkOutput("lw_imm", imm, 32'hFFFFFFFC);
    checkOutput("lw_mr", mem_read, 1);
    checkOutput("lw_rd", rd, 4);

    ex_mem_read = 1; ex_rd = 4;
    applyStimulus(1, 32'h00822820, 32'h10C, 1, 0); #1;
    checkOutput("lu_if_ready", if_ready, 0);
    step();
    checkOutput("lu_bubble_valid", id_valid, 0);
    checkOutput("lu_bubble_mr", mem_read, 0);
    step();
    checkOutput("lu_retry_rd", rd, 5);
    checkOutput("lu_retry_rt", rt_data, 7);

    applyStimulus(1, 32'h00223022, 32'h110, 0, 0);
    for (int k = 0; k < 3; k++) begin
      #1 checkOutput("hold_if_ready", if_ready, 0);
      step();
      checkOutput("hold_rd", rd, 5);
      checkOutput("hold_valid", id_valid, 1);
    end
    applyStimulus(1, 32'h00223022, 32'h110, 1, 0); step();
    checkOutput("sub_rd", rd, 6);
    checkOutput("sub_alu", alu_op, 1);

    applyStimulus(1, 32'h00223825, 32'h114, 1, 1); #1;
    checkOutput("flush_if_ready", if_ready, 1);
    step();
    checkOutput("flush_valid", id_valid, 0);
    checkOutput("flush_rw", reg_write, 0);

    applyStimulus(1, 32'hFC000000, 32'h118, 1, 0); step();
    checkOutput("ill_flag", illegal, 1);
    checkOutput("ill_rw", reg_write, 0);
    checkOutput("ill_valid", id_valid, 1);

    wb_we = 1; wb_addr = 1; wb_data = 32'hA5A5A5A5;
    applyStimulus(1, 32'h00224024, 32'h11C, 1, 0); step();
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp_rs", rs_data, 32'hA5A5A5A5);
`else
    checkOutput("byp_rs", rs_data, 5);
`endif
    checkOutput("and_alu", alu_op, 2);

    applyStimulus(1, 32'h00223825, 32'h120, 1, 0); step();
    checkOutput("or_rs", rs_data, 32'hA5A5A5A5);
    checkOutput("or_alu", alu_op, 3);

    wb_we = 1; wb_addr = 0; wb_data = 32'hDEADBEEF;
    applyStimulus(1, 32'h00014820, 32'h124, 1, 0); step();
    checkOutput("r0_rs", rs_data, 0);
    checkOutput("r0_rt", rt_data, 32'hA5A5A5A5);
    applyStimulus(1, 32'h0002602A, 32'h128, 1, 0); step();
    checkOutput("r0_after_rs", rs_data, 0);
    checkOutput("slt_alu", alu_op, 4);

    applyStimulus(1, 32'h204AFFFF, 32'h12C, 1, 0); step();
    checkOutput("addi_imm", imm, 32'hFFFFFFFF);
    checkOutput("addi_rd", rd, 10);

    ex_mem_read = 1; ex_rd = 11;
    applyStimulus(1, 32'h200B0001, 32'h130, 1, 0); #1;
    checkOutput("addi_rt_no_stall", if_ready, 1);
    step();
    ex_mem_read = 1; ex_rd = 0;
    applyStimulus(1, 32'hAC220008, 32'h134, 1, 0); #1;
    checkOutput("rd0_no_stall", if_ready, 1);
    step();
    checkOutput("sw_mw", mem_write, 1);
    checkOutput("sw_rd", rd, 0);

    applyStimulus(1, 32'h10220003, 32'h138, 1, 0); step();
    checkOutput("beq_br", branch, 1);
    applyStimulus(1, 32'h08000010, 32'h90000000, 1, 0); step();
    checkOutput("j_imm", imm, 32'h90000040);
    checkOutput("j_jump", jump, 1);
    applyStimulus(1, 32'h00221821, 32'h13C, 1, 0); step();
    checkOutput("addu_ill", illegal, 1);
    applyStimulus(0, 32'h00221820, 32'h140, 1, 0); step();
    checkOutput("bubble_valid", id_valid, 0);
    checkOutput("bubble_ill", illegal, 0);

    applyStimulus(1, 32'h00221820, 32'h200, 1, 0); step();
    applyStimulus(1, 32'h00223022, 32'h204, 1, 0); #2;
    rst = 1; #1;
    checkOutput("arst_valid", id_valid, 0);
    checkOutput("arst_rs", rs_data, 0);
    checkOutput("arst_rd", rd, 0);
    checkOutput("arst_pc", pc_out, 0);
    checkOutput("arst_rw", reg_write, 0);
    @(posedge clk); #1;
    rst = 0; #1;
    checkOutput("post_rst_if_ready", if_ready, 1);
    checkOutput("post_rst_valid", id_valid, 0);
    applyStimulus(1, 32'h00221820, 32'h208, 1, 0); step();
    checkOutput("post_rst_rs", rs_data, 0);
    checkOutput("post_rst_rt", rt_data, 0);
    checkOutput("post_rst_rd", rd, 3);

    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
